// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned NB_CNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // MIPS-style function codes, shared with benches driving the ALU model.
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_NOR = 6'b100111;

  // Index of the set bit in a 2-way one-hot vector.
  function automatic logic onehot_idx(input logic [N_REQ-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin picker: one-hot winner from requests and last winner.
module rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             last_i,
  output logic [N_REQ-1:0] grant_o
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant_o = '0;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto a shared ALU with fixed latency.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_ALU_OP   = 6,
  parameter int ALU_LATENCY = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [1:0]               i_req,
  input  logic [2*NB_DATA-1:0]     i_data_A,
  input  logic [2*NB_DATA-1:0]     i_data_B,
  input  logic [2*NB_ALU_OP-1:0]   i_op,
  output logic [1:0]               o_grant,
  output logic [1:0]               o_resp_valid,
  output logic [NB_DATA-1:0]       o_result,
  output logic [NB_DATA-1:0]       o_alu_data_A,
  output logic [NB_DATA-1:0]       o_alu_data_B,
  output logic [NB_ALU_OP-1:0]     o_alu_op,
  input  logic [NB_DATA-1:0]       i_alu_data_in,
  output logic                     o_busy
);

  state_e                 state_q, state_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   winner_q, winner_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]       resp_q, resp_d;
  logic [NB_DATA-1:0]     result_q, result_d;
  logic [NB_DATA-1:0]     alu_a_q, alu_a_d;
  logic [NB_DATA-1:0]     alu_b_q, alu_b_d;
  logic [NB_ALU_OP-1:0]   alu_op_q, alu_op_d;
  logic                   busy_q, busy_d;
  logic [N_REQ-1:0]       pick;
  logic                   pick_idx;

  rr_arbiter u_rr (
    .req_i   (i_req),
    .last_i  (last_q),
    .grant_o (pick)
  );

  assign pick_idx = onehot_idx(pick);

  // State and output registers; pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      grant_q  <= '0;
      resp_q   <= '0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      resp_q   <= resp_d;
      result_q <= result_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      busy_q   <= busy_d;
    end
  end

  // Next state; grant/resp pulses are computed one state early so they land registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    winner_d = winner_q;
    grant_d  = '0;
    resp_d   = '0;
    result_d = result_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          state_d  = ST_EXEC;
          grant_d  = pick;
          winner_d = pick_idx;
          last_d   = pick_idx;
          cnt_d    = NB_CNT'(ALU_LATENCY);
          alu_a_d  = pick_idx ? i_data_A[NB_DATA +: NB_DATA] : i_data_A[0 +: NB_DATA];
          alu_b_d  = pick_idx ? i_data_B[NB_DATA +: NB_DATA] : i_data_B[0 +: NB_DATA];
          alu_op_d = pick_idx ? i_op[NB_ALU_OP +: NB_ALU_OP] : i_op[0 +: NB_ALU_OP];
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d  = ST_RESP;
          result_d = i_alu_data_in;
          resp_d   = winner_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - NB_CNT'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign o_grant      = grant_q;
  assign o_resp_valid = resp_q;
  assign o_result     = result_q;
  assign o_alu_data_A = alu_a_q;
  assign o_alu_data_B = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: one zero-latency and one three-cycle-latency arbiter instance.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [1:0]  req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [11:0] op0, op1;
  logic [1:0]  grant0, grant1, resp0, resp1;
  logic [7:0]  result0, result1, alu_a0, alu_a1, alu_b0, alu_b1, alu_in0, alu_in1;
  logic [5:0]  alu_op0, alu_op1;
  logic        busy0, busy1;
  logic [3:0]  age1;
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  // Zero-latency ALU; the slow ALU only shows a valid result exactly 3 cycles after grant.
  assign alu_in0 = alu_f(alu_op0, alu_a0, alu_b0);
  assign alu_in1 = (age1 == 4'd3) ? alu_f(alu_op1, alu_a1, alu_b1) : 8'hEE;

  always @(posedge clk or posedge rst1) begin
    if (rst1) age1 <= 4'd0;
    else if (grant1 != 2'b00) age1 <= 4'd1;
    else if (age1 != 4'd0 && age1 < 4'd15) age1 <= age1 + 4'd1;
  end

  alu_arbiter #(.NB_DATA(8), .NB_ALU_OP(6), .ALU_LATENCY(0)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_req(req0), .i_data_A(a0), .i_data_B(b0), .i_op(op0),
    .o_grant(grant0), .o_resp_valid(resp0), .o_result(result0),
    .o_alu_data_A(alu_a0), .o_alu_data_B(alu_b0), .o_alu_op(alu_op0),
    .i_alu_data_in(alu_in0), .o_busy(busy0)
  );

  alu_arbiter #(.NB_DATA(8), .NB_ALU_OP(6), .ALU_LATENCY(3)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_req(req1), .i_data_A(a1), .i_data_B(b1), .i_op(op1),
    .o_grant(grant1), .o_resp_valid(resp1), .o_result(result1),
    .o_alu_data_A(alu_a1), .o_alu_data_B(alu_b1), .o_alu_op(alu_op1),
    .i_alu_data_in(alu_in1), .o_busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int unsigned which, output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (which == 0 && grant0 != 2'b00) begin g = grant0; return; end
      if (which == 1 && grant1 != 2'b00) begin g = grant1; return; end
    end
  endtask

  // Grant/response exclusivity on both instances, every cycle once out of reset.
  always @(negedge clk) begin
    if (mon_en) begin
      check("excl0", ($countones(grant0) <= 1) && ($countones(resp0) <= 1) && !(|grant0 && |resp0), 1);
      check("excl1", ($countones(grant1) <= 1) && ($countones(resp1) <= 1) && !(|grant1 && |resp1), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g;
    rst0 = 1'b1; rst1 = 1'b1;
    req0 = '0; req1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    repeat (2) @(negedge clk);
    check("rst_grant0", grant0, 0);
    check("rst_resp0", resp0, 0);
    check("rst_busy0", busy0, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_result0", result0, 0);
    check("rst_alu0", {alu_a0, alu_b0, alu_op0}, 0);
    check("rst_out1", {grant1, resp1, result1, alu_a1, busy1}, 0);

    // Single ADD on requester 0, zero latency.
    req0 = 2'b01; a0 = 16'h0005; b0 = 16'h0003; op0 = {6'h00, ALU_ADD};
    @(negedge clk);
    check("s1_grant", grant0, 2'b01);
    check("s1_busy", busy0, 1);
    check("s1_alu_a", alu_a0, 8'h05);
    check("s1_alu_b", alu_b0, 8'h03);
    check("s1_alu_op", alu_op0, ALU_ADD);
    check("s1_resp_early", resp0, 0);
    req0 = 2'b00;
    @(negedge clk);
    check("s1_resp", resp0, 2'b01);
    check("s1_result", result0, 8'h08);
    check("s1_grant_pulse", grant0, 0);
    check("s1_busy_resp", busy0, 1);
    @(negedge clk);
    check("s1_idle_busy", busy0, 0);
    check("s1_idle_resp", resp0, 0);
    check("s1_hold_result", result0, 8'h08);
    check("s1_hold_alu_a", alu_a0, 8'h05);

    // SUB on requester 1.
    req0 = 2'b10; a0 = 16'h0900; b0 = 16'h0400; op0 = {ALU_SUB, 6'h00};
    wait_grant(0, g);
    check("sub_grant", g, 2'b10);
    req0 = 2'b00;
    @(negedge clk);
    check("sub_resp", resp0, 2'b10);
    check("sub_result", result0, 8'h05);
    @(negedge clk);

    // Both held: pointer last went to requester 1, so grants run 0,1,0,1.
    req0 = 2'b11; a0 = 16'h0201; b0 = 16'h0201; op0 = {ALU_ADD, ALU_ADD};
    for (int k = 0; k < 4; k++) begin
      wait_grant(0, g);
      check("rr_grant", g, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      check("rr_resp", resp0, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_result", result0, (k % 2 == 0) ? 8'h02 : 8'h04);
    end
    req0 = 2'b00;
    @(negedge clk);

    // Requester 1 pulses only while requester 0 is being served.
    req0 = 2'b01; a0 = 16'h7710; b0 = 16'h7720; op0 = {ALU_ADD, ALU_ADD};
    wait_grant(0, g);
    check("late_grant0", g, 2'b01);
    req0 = 2'b10;
    @(negedge clk);
    check("late_resp0", resp0, 2'b01);
    check("late_result0", result0, 8'h30);
    req0 = 2'b00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("late_no_grant1", grant0, 0);
    end

    // Slow ALU: warm-up op gives a non-zero result first.
    req1 = 2'b01; a1 = 16'h0003; b1 = 16'h0004; op1 = {ALU_ADD, ALU_ADD};
    wait_grant(1, g);
    check("l3_warm_grant", g, 2'b01);
    req1 = 2'b00;
    repeat (4) @(negedge clk);
    check("l3_warm_resp", resp1, 2'b01);
    check("l3_warm_result", result1, 8'h07);
    @(negedge clk);

    // Slow ALU: 0xFF + 0x01 wraps; response exactly 4 cycles after grant.
    req1 = 2'b10; a1 = 16'hFF00; b1 = 16'h0100; op1 = {ALU_ADD, ALU_ADD};
    wait_grant(1, g);
    check("l3_grant", g, 2'b10);
    check("l3_busy_t0", busy1, 1);
    req1 = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("l3_busy", busy1, 1);
      check("l3_resp", resp1, (k == 4) ? 2'b10 : 2'b00);
      if (k == 4) check("l3_result", result1, 8'h00);
    end
    @(negedge clk);
    check("l3_idle_busy", busy1, 0);

    // Reset in the cycle after grant[0] aborts the operation.
    req1 = 2'b01; a1 = 16'h0011; b1 = 16'h0022; op1 = {ALU_ADD, ALU_ADD};
    wait_grant(1, g);
    check("rst_mid_grant", g, 2'b01);
    req1 = 2'b00;
    @(posedge clk);
    #2 rst1 = 1'b1;
    #1;
    check("rst_mid_outs", {grant1, resp1, result1, alu_a1, alu_b1, alu_op1, busy1}, 0);
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_no_resp", resp1, 0);
    end
    req1 = 2'b11; a1 = 16'h0503; b1 = 16'h0504; op1 = {ALU_ADD, ALU_ADD};
    wait_grant(1, g);
    check("rst_tie_grant", g, 2'b01);
    req1 = 2'b00;
    repeat (4) @(negedge clk);
    check("rst_post_resp", resp1, 2'b01);
    check("rst_post_result", result1, 8'h07);
    @(negedge clk);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
